// File: rtl/decode_q_pkg.sv
// decode_q_pkg: shared types for the queued decode stage.
//   PipeControl  - stall/flush from the pipeline controller
//   PipeRequest  - stall/flush requests raised by decode
//   DecodeInfo   - decoded instruction, also the ID/EX register format
//   HazardSlot   - one entry of the load-use history
package decode_q_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;

  typedef struct packed {
    logic       stall_req;
    logic [3:0] flush_req;
  } PipeRequest;

  typedef struct packed {
    logic        enable;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_en;
    logic        rs2_en;
    logic        reg_write;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        alt;        // sub / sra / srai selector
    logic        alu_imm;    // second ALU operand is imm
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic        is_muldiv;
  } DecodeInfo;

  typedef struct packed {
    logic       enable;
    logic       mem_to_reg;
    logic [4:0] rd;
  } HazardSlot;

  // A history slot blocks the head when it is an in-flight load whose
  // non-zero destination is a source the head actually reads.
  function automatic logic slot_hit(input HazardSlot s,
                                    input logic [4:0] rs1, input logic rs1_en,
                                    input logic [4:0] rs2, input logic rs2_en);
    return s.enable && s.mem_to_reg && (s.rd != 5'd0) &&
           ((rs1_en && (rs1 == s.rd)) || (rs2_en && (rs2 == s.rd)));
  endfunction

endpackage

// File: rtl/decode_q_inst_decoder.sv
// inst_decoder: pure combinational RV32I (+ optional RV32M) decoder.
//   pc_i, inst_i  - instruction to decode
//   info_o        - decoded fields; enable set when the encoding is legal
//   illegal_o     - encoding not supported
// Source-enable bits stay low for illegal encodings so they never raise
// a load-use hazard.
module inst_decoder
  import decode_q_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output DecodeInfo   info_o,
  output logic        illegal_o
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                   inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'b0};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                   inst_i[30:21], 1'b0};

  always_comb begin
    info_o        = '0;
    illegal_o     = 1'b1;
    info_o.pc     = pc_i;
    info_o.rs1    = inst_i[19:15];
    info_o.rs2    = inst_i[24:20];
    info_o.funct3 = f3;
    unique case (opcode)
      OP_LUI: begin
        illegal_o = 1'b0; info_o.lui = 1'b1; info_o.reg_write = 1'b1;
        info_o.imm = imm_u;
      end
      OP_AUIPC: begin
        illegal_o = 1'b0; info_o.auipc = 1'b1; info_o.reg_write = 1'b1;
        info_o.imm = imm_u;
      end
      OP_JAL: begin
        illegal_o = 1'b0; info_o.jal = 1'b1; info_o.reg_write = 1'b1;
        info_o.imm = imm_j;
      end
      OP_JALR: if (f3 == 3'd0) begin
        illegal_o = 1'b0; info_o.jalr = 1'b1; info_o.reg_write = 1'b1;
        info_o.rs1_en = 1'b1; info_o.imm = imm_i;
      end
      OP_BRANCH: if (f3 != 3'd2 && f3 != 3'd3) begin
        illegal_o = 1'b0; info_o.branch = 1'b1;
        info_o.rs1_en = 1'b1; info_o.rs2_en = 1'b1; info_o.imm = imm_b;
      end
      OP_LOAD: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        illegal_o = 1'b0; info_o.mem_to_reg = 1'b1; info_o.reg_write = 1'b1;
        info_o.rs1_en = 1'b1; info_o.alu_imm = 1'b1; info_o.imm = imm_i;
      end
      OP_STORE: if (f3 inside {3'd0, 3'd1, 3'd2}) begin
        illegal_o = 1'b0; info_o.mem_write = 1'b1;
        info_o.rs1_en = 1'b1; info_o.rs2_en = 1'b1; info_o.alu_imm = 1'b1;
        info_o.imm = imm_s;
      end
      OP_IMM: if ((f3 == 3'd1) ? (f7 == F7_BASE) :
                  (f3 == 3'd5) ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1) begin
        illegal_o = 1'b0; info_o.reg_write = 1'b1; info_o.rs1_en = 1'b1;
        info_o.alu_imm = 1'b1; info_o.imm = imm_i;
        info_o.alt = (f3 == 3'd5) && inst_i[30];
      end
      OP_REG: if ((f7 == F7_BASE) ||
                  (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)) ||
                  ((ENABLE_M != 0) && f7 == F7_MULDIV)) begin
        illegal_o = 1'b0; info_o.reg_write = 1'b1;
        info_o.rs1_en = 1'b1; info_o.rs2_en = 1'b1;
        info_o.alt = inst_i[30];
        info_o.is_muldiv = (f7 == F7_MULDIV);
      end
      default: ;
    endcase
    info_o.rd     = info_o.reg_write ? inst_i[11:7] : 5'd0;
    info_o.enable = !illegal_o;
  end

endmodule

// File: rtl/decode_q.sv
// decode_q: DEPTH-entry instruction queue between fetch and decode, with
// head decode, multi-cycle load-use detection and a registered ID/EX slot.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - fetch handshake for {in_pc, in_inst}
//   pipe                - stall holds the read side, flush kills everything
//   req                 - stall_req on load-use hazard; flush_req unused (0)
//   info_ff             - ID/EX register
//   error, err_pc       - one-cycle pulse / PC of a dropped illegal head
//   count               - queue occupancy
module decode_q
  import decode_q_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ENABLE_M = 1,
  parameter int LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_pc,
  input  logic [31:0]             in_inst,
  input  PipeControl              pipe,
  output PipeRequest              req,
  output DecodeInfo               info_ff,
  output logic                    error,
  output logic [31:0]             err_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  DecodeInfo     info_q, info_d;
  logic          error_q;
  logic [31:0]   err_pc_q;

  DecodeInfo     dec;
  logic          illegal, head_valid, hazard, hist_hit;
  logic          push, pop, drop, issue, advance;
  HazardSlot     slot0;

  // in_ready is purely occupancy based: a full queue refuses even on a
  // cycle that also dequeues.
  assign in_ready   = count_q < CW'(DEPTH);
  assign head_valid = count_q != '0;
  assign push       = in_valid && in_ready && !pipe.flush;
  assign advance    = !pipe.flush && !pipe.stall;

  inst_decoder #(.ENABLE_M(ENABLE_M)) u_dec (
    .pc_i      (pc_mem[rd_ptr_q]),
    .inst_i    (inst_mem[rd_ptr_q]),
    .info_o    (dec),
    .illegal_o (illegal)
  );

  // Slot 0 of the history is the ID/EX register itself; older occupants
  // live in hist_q only when the load latency reaches past ID/EX.
  assign slot0 = '{enable: info_q.enable, mem_to_reg: info_q.mem_to_reg,
                   rd: info_q.rd};

  if (LOAD_LAT > 1) begin : g_hist
    HazardSlot [LOAD_LAT-2:0] hist_q;

    always_ff @(posedge clk) begin
      if (rst || pipe.flush) begin
        hist_q <= '0;
      end else if (!pipe.stall) begin
        hist_q[0] <= slot0;
        for (int j = 1; j < LOAD_LAT - 1; j++) hist_q[j] <= hist_q[j-1];
      end
    end

    always_comb begin
      hist_hit = 1'b0;
      for (int j = 0; j < LOAD_LAT - 1; j++)
        if (slot_hit(hist_q[j], dec.rs1, dec.rs1_en, dec.rs2, dec.rs2_en))
          hist_hit = 1'b1;
    end
  end else begin : g_nohist
    assign hist_hit = 1'b0;
  end

  assign hazard = head_valid &&
                  (slot_hit(slot0, dec.rs1, dec.rs1_en, dec.rs2, dec.rs2_en) ||
                   hist_hit);

  // Illegal outranks hazard: a bad head is dropped even if it would stall.
  assign drop  = advance && head_valid && illegal;
  assign issue = advance && head_valid && !illegal && !hazard;
  assign pop   = drop || issue;

  assign count_d = count_q + CW'(push) - CW'(pop);
  assign info_d  = issue ? dec : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      info_q   <= '0;
      error_q  <= 1'b0;
      err_pc_q <= '0;
    end else begin
      error_q <= drop;
      if (drop) err_pc_q <= pc_mem[rd_ptr_q];
      if (pipe.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        info_q   <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_d;
        if (!pipe.stall) info_q <= info_d;
      end
    end
  end

  assign req.stall_req = hazard;
  assign req.flush_req = 4'b0000;
  assign info_ff       = info_q;
  assign error         = error_q;
  assign err_pc        = err_pc_q;
  assign count         = count_q;

endmodule

// File: tb/tb_decode_q.sv
module tb_decode_q;
  import decode_q_pkg::*;

  localparam logic [31:0] ADDI1 = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] ADDI2 = 32'h00200113;  // addi x2,x0,2
  localparam logic [31:0] ADDI3 = 32'h00300193;  // addi x3,x0,3
  localparam logic [31:0] ADDI4 = 32'h00400213;  // addi x4,x0,4
  localparam logic [31:0] LW5   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] ADD   = 32'h00728333;  // add x6,x5,x7
  localparam logic [31:0] LW0   = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] ADDX0 = 32'h00700333;  // add x6,x0,x7
  localparam logic [31:0] MUL   = 32'h022081B3;  // mul x3,x1,x2

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc, in_inst;
  PipeControl  pipe;

  logic        in_ready, error, m0_in_ready, m0_error;
  logic [31:0] err_pc, m0_err_pc;
  logic [2:0]  count, m0_count;
  PipeRequest  req, m0_req;
  DecodeInfo   info_ff, m0_info_ff;

  always #5 clk = ~clk;

  decode_q #(.DEPTH(4), .ENABLE_M(1), .LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .pipe(pipe), .req(req),
    .info_ff(info_ff), .error(error), .err_pc(err_pc), .count(count)
  );

  decode_q #(.DEPTH(4), .ENABLE_M(0), .LOAD_LAT(1)) dut_m0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m0_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .pipe(pipe), .req(m0_req),
    .info_ff(m0_info_ff), .error(m0_error), .err_pc(m0_err_pc),
    .count(m0_count)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stall;
    logic        flush;
    int          cnt;
    logic        en;
    logic [31:0] epc;
    logic        sreq;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic st, input logic fl, input int c, input logic en,
                     input logic [31:0] epc, input logic sr, input logic rdy);
    vec_t r;
    r = '{vld: v, pc: pc, inst: inst, stall: st, flush: fl, cnt: c, en: en,
          epc: epc, sreq: sr, rdy: rdy};
    vecs.push_back(r);
  endtask

  initial begin
    // Back-to-back addi stream: one per cycle, count stays at 1.
    add(1, 32'h00, ADDI1, 0, 0, 1, 0, 0,     0, 1);
    add(1, 32'h04, ADDI2, 0, 0, 1, 1, 32'h0, 0, 1);
    add(1, 32'h08, ADDI3, 0, 0, 1, 1, 32'h4, 0, 1);
    add(1, 32'h0C, ADDI4, 0, 0, 1, 1, 32'h8, 0, 1);
    add(0, 0,      0,     0, 0, 0, 1, 32'hC, 0, 1);
    add(0, 0,      0,     0, 0, 0, 0, 0,     0, 1);
    // lw x5 / add x5 with LOAD_LAT=2: two bubbles, stall_req two cycles.
    add(1, 32'h10, LW5,   0, 0, 1, 0, 0,      0, 1);
    add(1, 32'h14, ADD,   0, 0, 1, 1, 32'h10, 1, 1);
    add(0, 0,      0,     0, 0, 1, 0, 0,      1, 1);
    add(0, 0,      0,     0, 0, 1, 0, 0,      0, 1);
    add(0, 0,      0,     0, 0, 0, 1, 32'h14, 0, 1);
    add(0, 0,      0,     0, 0, 0, 0, 0,      0, 1);
    // Load to x0 never blocks, even against an x0 source.
    add(1, 32'h20, LW0,   0, 0, 1, 0, 0,      0, 1);
    add(1, 32'h24, ADDX0, 0, 0, 1, 1, 32'h20, 0, 1);
    add(0, 0,      0,     0, 0, 0, 1, 32'h24, 0, 1);
    add(0, 0,      0,     0, 0, 0, 0, 0,      0, 1);
    // Stall 6 cycles while fetch streams: fills to 4, refuses the rest.
    add(1, 32'h30, ADDI1, 1, 0, 1, 0, 0, 0, 1);
    add(1, 32'h34, ADDI1, 1, 0, 2, 0, 0, 0, 1);
    add(1, 32'h38, ADDI1, 1, 0, 3, 0, 0, 0, 1);
    add(1, 32'h3C, ADDI1, 1, 0, 4, 0, 0, 0, 0);
    add(1, 32'h40, ADDI1, 1, 0, 4, 0, 0, 0, 0);
    add(1, 32'h40, ADDI1, 1, 0, 4, 0, 0, 0, 0);
    // Release: full queue still refuses on the first dequeue cycle.
    add(1, 32'h40, ADDI1, 0, 0, 3, 1, 32'h30, 0, 1);
    add(1, 32'h40, ADDI1, 0, 0, 3, 1, 32'h34, 0, 1);
    add(0, 0,      0,     0, 0, 2, 1, 32'h38, 0, 1);
    add(0, 0,      0,     0, 0, 1, 1, 32'h3C, 0, 1);
    add(0, 0,      0,     0, 0, 0, 1, 32'h40, 0, 1);
    add(0, 0,      0,     0, 0, 0, 0, 0,      0, 1);
    // Flush (with stall and in_valid) while count=3 and a load in history.
    add(1, 32'h4C, LW5,   0, 0, 1, 0, 0,      0, 1);
    add(1, 32'h50, ADDI1, 0, 0, 1, 1, 32'h4C, 0, 1);
    add(1, 32'h54, ADDI1, 0, 0, 1, 1, 32'h50, 0, 1);
    add(1, 32'h58, ADDI1, 1, 0, 2, 1, 32'h50, 0, 1);
    add(1, 32'h5C, ADDI1, 1, 0, 3, 1, 32'h50, 0, 1);
    add(1, 32'h60, ADDI1, 1, 1, 0, 0, 0,      0, 1);
    add(1, 32'h64, ADD,   0, 0, 1, 0, 0,      0, 1);
    add(0, 0,      0,     0, 0, 0, 1, 32'h64, 0, 1);

    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; pipe = '0;
    step();
    step();
    chk("reset count",    32'(count),         32'd0);
    chk("reset enable",   32'(info_ff.enable), 32'd0);
    chk("reset in_ready", 32'(in_ready),      32'd1);
    chk("reset stallreq", 32'(req.stall_req), 32'd0);
    chk("reset flushreq", 32'(req.flush_req), 32'd0);
    chk("reset error",    32'(error),         32'd0);
    chk("reset err_pc",   err_pc,             32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      in_valid   = vecs[i].vld;
      in_pc      = vecs[i].pc;
      in_inst    = vecs[i].inst;
      pipe.stall = vecs[i].stall;
      pipe.flush = vecs[i].flush;
      step();
      chk($sformatf("v%0d count", i),    32'(count),          32'(vecs[i].cnt));
      chk($sformatf("v%0d enable", i),   32'(info_ff.enable), 32'(vecs[i].en));
      if (vecs[i].en) chk($sformatf("v%0d pc", i), info_ff.pc, vecs[i].epc);
      chk($sformatf("v%0d stallreq", i), 32'(req.stall_req),  32'(vecs[i].sreq));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready),       32'(vecs[i].rdy));
      chk($sformatf("v%0d error", i),    32'(error),          32'd0);
    end

    // Reset mid-operation discards a queued entry.
    pipe = '0; in_valid = 1'b1; in_pc = 32'h70; in_inst = ADDI1;
    step();
    chk("pre-reset count", 32'(count), 32'd1);
    rst = 1'b1;
    step();
    chk("midreset count",    32'(count),    32'd0);
    chk("midreset m0 count", 32'(m0_count), 32'd0);
    chk("midreset enable",   32'(info_ff.enable), 32'd0);
    rst = 1'b0;

    // mul at 0x40 followed by addi at 0x44, on both M configurations.
    in_valid = 1'b1; in_pc = 32'h40; in_inst = MUL;
    step();
    chk("mul count",    32'(count),    32'd1);
    chk("mul m0 count", 32'(m0_count), 32'd1);
    in_pc = 32'h44; in_inst = ADDI1;
    step();
    chk("mul enable",      32'(info_ff.enable),    32'd1);
    chk("mul pc",          info_ff.pc,             32'h40);
    chk("mul is_muldiv",   32'(info_ff.is_muldiv), 32'd1);
    chk("mul error",       32'(error),             32'd0);
    chk("m0 drop enable",  32'(m0_info_ff.enable), 32'd0);
    chk("m0 drop error",   32'(m0_error),          32'd1);
    chk("m0 drop err_pc",  m0_err_pc,              32'h40);
    chk("m0 drop count",   32'(m0_count),          32'd1);
    in_valid = 1'b0;
    step();
    chk("addi pc",         info_ff.pc,             32'h44);
    chk("addi is_muldiv",  32'(info_ff.is_muldiv), 32'd0);
    chk("m0 next enable",  32'(m0_info_ff.enable), 32'd1);
    chk("m0 next pc",      m0_info_ff.pc,          32'h44);
    chk("m0 error pulse",  32'(m0_error),          32'd0);
    chk("m0 err_pc hold",  m0_err_pc,              32'h40);
    step();
    chk("m0 error idle",   32'(m0_error),          32'd0);
    chk("m0 err_pc kept",  m0_err_pc,              32'h40);
    chk("m0 final count",  32'(m0_count),          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_q.md
# decode_q

Parametrised successor to the single-slot decode stage: an instruction queue of DEPTH entries between fetch and decode. It decodes the queue head, with RV32I plus optional RV32M. Load-use hazard detection covers a configurable load latency instead of one stage. The block registers the decoded result into the ID/EX slot, so fetch keeps running while decode is stalled by hazards or back-pressure.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- ENABLE_M, 1: 1 decodes RV32M (opcode 0110011, funct7 0000001); 0 treats it as illegal.
- LOAD_LAT, 1: cycles after a load leaves ID/EX before its result is forwardable; 1..3.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high.
- in_valid  in  1  fetch offers {in_pc, in_inst}.
- in_ready  out  1  queue can accept; equals count < DEPTH.
- in_pc  in  32  fetched PC.
- in_inst  in  32  fetched instruction.
- pipe  in  PipeControl  .stall holds stage; .flush kills queue and ID/EX.
- req  out  PipeRequest  .stall_req = load-use hazard on head; .flush_req = 4'b0000.
- info_ff  out  DecodeInfo  ID/EX register; .enable marks a valid instruction.
- error  out  1  registered; one-cycle pulse when an illegal head is dropped.
- err_pc  out  32  PC of the dropped instruction; holds until the next error.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Queue: circular buffer, rd/wr pointers of $clog2(DEPTH) bits wrap naturally; count tracked separately.
- Enqueue when in_valid && in_ready && !pipe.flush.
- Head decode (combinational) uses the existing field map: I/R/load/store/B/LUI/AUIPC/JAL/JALR, with imm_i/s/b/u/j; JALR uses imm_i. M ops: R-type control plus is_muldiv=1.
- Hazard: history of the last LOAD_LAT ID/EX occupants {rd, mem_to_reg, enable}, with slot 0 = info_ff. It shifts on every non-stalled cycle; bubbles shift in zeros.
- hazard = head valid && some history slot has enable && mem_to_reg && rd≠0 && rd matches a valid head rs1/rs2.
- Update priority per cycle, rst > flush > stall > illegal > hazard > issue:
  - flush: queue emptied, info_ff←0, history←0.
  - stall: queue read side, info_ff and history held; enqueue still permitted.
  - illegal head: dequeued; info_ff←0; error←1; err_pc←head pc.
  - hazard: nothing dequeued; info_ff←0 (bubble).
  - issue: head dequeued; info_ff←decoded head.
  - empty: info_ff←0.
- Simultaneous enqueue and dequeue: count unchanged. in_ready does not look ahead, so a full queue refuses even while dequeuing.

## Timing
- Reset: count 0, pointers 0, info_ff 0, history 0, error 0, err_pc 0, in_ready 1, req.stall_req 0.
- Latency: instruction accepted at edge t is the head during t+1 and lands in info_ff at edge t+2 if unobstructed.
- Throughput: one instruction per cycle with a steady supply.
- req.stall_req is combinational from head and history, and is asserted for exactly LOAD_LAT−k cycles when the producing load sits in history slot k.
- error is high for one cycle only, following the drop edge.
- Flush in the same cycle as in_valid: that instruction is discarded; in_ready is high the next cycle.
- Reset mid-operation discards queue contents; no partial state survives.

## Structure
- In common.sv:
  - DecodeInfo gains is_muldiv.
  - Opcode localparams.
  - A HazardSlot typedef {enable, mem_to_reg, rd}.
- Sub-module inst_decoder: pure combinational pc/inst → DecodeInfo plus illegal, with ENABLE_M passed down; reused by later multi-issue work.
- decode_q holds the queue, hazard history and ID/EX register.

## Test plan
- Back-to-back addi x1..x4 with in_valid steady: info_ff.enable high from cycle 2; PCs 0,4,8,12 in order; count ≤1.
- lw x5,0(x1) then add x6,x5,x7 with LOAD_LAT=2: exactly 2 bubbles; req.stall_req high 2 cycles; add issues on the third cycle.
- Same pair with rd=x0: no bubble, no stall_req.
- pipe.stall held 6 cycles with fetch streaming, DEPTH=4:
  - count saturates at 4 and in_ready drops;
  - after release, entries issue in order with no loss or duplication.
- pipe.flush with count=3 plus a concurrent in_valid: next cycle count=0, info_ff.enable=0, history clear.
- mul x3,x1,x2 (0x022081B3) at pc 0x40:
  - ENABLE_M=1: issues with is_muldiv=1.
  - ENABLE_M=0: error pulses one cycle, err_pc=0x40, and the next instruction issues normally.
